// File: rtl/mem_line_arbiter.sv
// Shares one slow line-based memory port among NUM_CH cache channels.
// A winner is latched in IDLE, held through BUSY and followed by a one-cycle RELEASE.
module mem_line_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 28,
  parameter int LINE_W   = 128,
  parameter int ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_ready
);

  localparam int GW = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     rr_ptr;
  logic [NUM_CH-1:0] req;
  logic              any_req;
  logic              found;
  logic [GW-1:0]     win;

  always_comb begin
    req     = ch_read | ch_write;
    any_req = |req;
    found   = 1'b0;
    win     = '0;
    if (ARB_MODE == 1) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!found && req[i]) begin
          win   = GW'(i);
          found = 1'b1;
        end
      end
    end else begin
      // Scan from rr_ptr upward, wrapping past the last channel.
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (!found && req[(32'(rr_ptr) + k) % NUM_CH]) begin
          win   = GW'((32'(rr_ptr) + k) % NUM_CH);
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= win;
            mem_addr  <= ch_addr[win*ADDR_W +: ADDR_W];
            mem_wdata <= ch_wdata[win*LINE_W +: LINE_W];
            mem_write <= ch_write[win];
            mem_read  <= ~ch_write[win];
            state     <= BUSY;
          end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (ARB_MODE == 0)
              rr_ptr <= (grant == GW'(NUM_CH - 1)) ? '0 : grant + GW'(1);
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ch_ready = '0;
    if (state == BUSY && mem_ready)
      ch_ready[grant] = 1'b1;
  end

  assign ch_rdata = mem_rdata;

endmodule
